ble_cfg_lut: RTL and testbench
==============================

# ble_cfg_lut

Configurable basic logic element (BLE) for the FPGA fabric. It combines a K-input look-up table with an optional output flip-flop, and both are programmed through a serial, daisy-chainable configuration shift register. It is the parametrised successor to the fixed 16:1 LUT mux. One instance sits in each logic block, and the configuration chains of all BLEs are concatenated into the fabric bitstream.

## Interface
Parameters:
- K, default 4: number of LUT inputs; legal range 2..6.
- CFG_W, default 2^K+2: configuration length; derived, must not be overridden.

Ports:
- clk  input  1  fabric clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cfg_en  input  1  configuration shift enable.
- cfg_din  input  1  serial configuration data in.
- cfg_dout  output  1  serial configuration data out, to the next BLE in the chain.
- cfg_done  output  1  high when a full CFG_W-bit configuration has been loaded.
- lut_in  input  K  LUT select inputs.
- ce  input  1  flip-flop clock enable.
- ble_out  output  1  BLE output.

## Operation
Configuration register layout (cfg_sr, CFG_W bits):
- cfg_sr[2^K-1:0]: LUT truth table.
- cfg_sr[2^K]: FF_EN.
- cfg_sr[2^K+1]: FF_INIT.

Shifting:
- On each edge with cfg_en=1: cfg_sr <= {cfg_din, cfg_sr[CFG_W-1:1]}.
- cfg_dout = cfg_sr[0], driven combinationally from the register.
- Bit order on the chain: LUT bit 0 is sent first and FF_INIT is sent last.
- Shifting past CFG_W bits continues and passes data downstream. Only the last CFG_W bits shifted in are retained.

Bit counter (cfg_cnt, width $clog2(CFG_W+1)):
- Increments on each shift edge and saturates at CFG_W.
- cfg_done = (cfg_cnt == CFG_W), registered.
- A new session starts when cfg_en rises: cfg_en=1 while cfg_en_q=0 (cfg_en_q is cfg_en delayed by one clock).
  - The counter loads 1 on that edge, counting that edge's shift, so cfg_done drops.
  - This applies both on the first load and on a reconfiguration.

LUT:
- lut_val = cfg_sr[lut_in], purely combinational.

Flip-flop (ff_q):
- While cfg_en=1: ff_q <= cfg_din on every edge. At the end of a load, ff_q therefore equals FF_INIT.
- While cfg_en=0 and cfg_done=1 and ce=1: ff_q <= lut_val.
- Otherwise ff_q holds.

Output:
- ble_out = (cfg_done & ~cfg_en) ? (FF_EN ? ff_q : lut_val) : 0.
- The output is forced to 0 while unconfigured or while shifting.

## Timing
- Reset values: cfg_sr=0, cfg_cnt=0, cfg_en_q=0, ff_q=0. Therefore cfg_dout=0, cfg_done=0, ble_out=0.
- Reset takes effect immediately on assertion, with no clock needed. Release is synchronous to the first subsequent edge.
- Reset mid-load discards the partial configuration. A full CFG_W-bit reload is required afterwards.
- cfg_done rises on the edge of the CFG_W-th consecutive-session shift. It is visible in the cycle after that edge.
- Configured values are usable in the first cycle after cfg_en falls, provided cfg_done=1.
- FF_EN=0: lut_in to ble_out is combinational, with zero latency.
- FF_EN=1:
  - ble_out shows FF_INIT in the first usable cycle.
  - A lut_in value sampled on an edge with ce=1 appears one cycle later.
  - With ce=0, the output holds.
- cfg_en rising while cfg_done=1: ble_out goes to 0 in the same cycle (combinational gating), and cfg_done falls after that edge.
- cfg_en pulsed low and high before CFG_W shifts: a new session starts and the count restarts at 1.
- Simultaneous ce=1 and cfg_en=1: configuration wins, and ff_q <= cfg_din.
- cfg_dout presents the first bit shifted in after exactly CFG_W shifts. It emerges downstream on shift CFG_W+1.

## Test plan
- AND4 combinational (K=4):
  - Stimulus: shift 18 bits (bit 15=1, other LUT bits 0, FF_EN=0, FF_INIT=0), then drop cfg_en.
  - Required: cfg_done=1; lut_in=4'hF gives ble_out=1; lut_in=4'hE gives ble_out=0, checked with no clock edge.
- Registered XOR (K=4):
  - Stimulus: load the 4-input XOR truth table with FF_EN=1, FF_INIT=1.
  - Required: ble_out=1 after load. Then ce=1 with lut_in=4'b0011 gives ble_out=0 one edge later. Then ce=0 with lut_in=4'b0001 leaves ble_out at 0.
- Reset mid-load:
  - Stimulus: assert rst_n=0 asynchronously after 7 shifts.
  - Required: cfg_done=0, ble_out=0 and cfg_dout=0 immediately. A subsequent full 18-bit load gives the correct function.
- Reconfiguration:
  - Stimulus: while configured as AND4, raise cfg_en.
  - Required: ble_out=0 the same cycle and cfg_done=0 after the edge. After 18 shifts of an OR4 table, lut_in=4'h1 gives ble_out=1.
- Daisy chain:
  - Stimulus: chain two instances via cfg_dout to cfg_din and shift 36 bits (downstream config first).
  - Required: both report cfg_done=1 and implement their respective functions. An 18-bit-only shift leaves the downstream instance holding the upstream's intended bits.
- Over-shift:
  - Stimulus: shift 20 bits into a single instance.
  - Required: cfg_cnt saturates at 18, cfg_done=1, and cfg_sr holds the last 18 bits. cfg_dout shows the 3rd bit shifted in.

Source files
------------

// File: rtl/ble_cfg_lut.sv
// ble_cfg_lut -- configurable basic logic element (BLE).
//
// A K-input look-up table followed by an optional output flip-flop. Both are
// programmed through a serial configuration shift register that can be
// daisy-chained: cfg_dout of one BLE drives cfg_din of the next.
//
// Configuration register layout (cfg_sr, CFG_W bits; bit 0 is shifted in first):
//   [2^K-1:0]  LUT truth table, indexed by lut_in
//   [2^K]      FF_EN   - 1: ble_out comes from the flip-flop, 0: straight from the LUT
//   [2^K+1]    FF_INIT - flip-flop value when the load ends
//
// Ports:
//   clk       fabric clock, rising edge
//   rst_n     asynchronous active-low reset
//   cfg_en    configuration shift enable
//   cfg_din   serial configuration data in
//   cfg_dout  serial configuration data out (cfg_sr[0]) to the next BLE
//   cfg_done  high once a full CFG_W-bit configuration has been loaded
//   lut_in    LUT select inputs (K bits)
//   ce        flip-flop clock enable
//   ble_out   BLE output; forced to 0 while unconfigured or while shifting
module ble_cfg_lut #(
  parameter int K     = 4,
  parameter int CFG_W = (1 << K) + 2   // derived from K; do not override
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_en,
  input  logic         cfg_din,
  output logic         cfg_dout,
  output logic         cfg_done,
  input  logic [K-1:0] lut_in,
  input  logic         ce,
  output logic         ble_out
);

  localparam int LUT_N = 1 << K;
  localparam int CNT_W = $clog2(CFG_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CFG_W-1:0] cfg_sr_q,   cfg_sr_d;
  logic [CNT_W-1:0] cfg_cnt_q,  cfg_cnt_d;
  logic             cfg_en_q,   cfg_en_d;
  logic             cfg_done_q, cfg_done_d;
  logic             ff_q,       ff_d;

  logic [LUT_N-1:0] lut_tt;
  logic             ff_en;
  logic             lut_val;
  logic             usable;

  assign lut_tt  = cfg_sr_q[LUT_N-1:0];
  assign ff_en   = cfg_sr_q[LUT_N];
  assign lut_val = lut_tt[lut_in];

  // Outputs are only meaningful with a complete configuration and no shift in
  // progress; raising cfg_en gates ble_out off in the same cycle.
  assign usable   = cfg_done_q & ~cfg_en;
  assign ble_out  = usable ? (ff_en ? ff_q : lut_val) : 1'b0;
  assign cfg_dout = cfg_sr_q[0];
  assign cfg_done = cfg_done_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned, which would infer a latch.
    cfg_sr_d  = cfg_sr_q;
    cfg_cnt_d = cfg_cnt_q;
    ff_d      = ff_q;
    cfg_en_d  = cfg_en;

    if (cfg_en) begin
      cfg_sr_d = {cfg_din, cfg_sr_q[CFG_W-1:1]};
      // A rising cfg_en opens a new session: this edge is shift number one.
      if (!cfg_en_q) begin
        cfg_cnt_d = CNT_ONE;
      end else if (cfg_cnt_q != CNT_FULL) begin
        cfg_cnt_d = cfg_cnt_q + CNT_ONE;
      end
      // The flop tracks the serial stream, so it holds FF_INIT (the last bit
      // shifted) when the load ends. Configuration overrides ce.
      ff_d = cfg_din;
    end else if (cfg_done_q && ce) begin
      ff_d = lut_val;
    end

    // Registered from the next count so cfg_done rises on the edge of the
    // CFG_W-th shift and drops on the edge that opens a new session.
    cfg_done_d = (cfg_cnt_d == CNT_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      cfg_sr_q   <= '0;
      cfg_cnt_q  <= '0;
      cfg_en_q   <= 1'b0;
      cfg_done_q <= 1'b0;
      ff_q       <= 1'b0;
    end else begin
      cfg_sr_q   <= cfg_sr_d;
      cfg_cnt_q  <= cfg_cnt_d;
      cfg_en_q   <= cfg_en_d;
      cfg_done_q <= cfg_done_d;
      ff_q       <= ff_d;
    end
  end

endmodule

// File: tb/tb_ble_cfg_lut.sv
// tb_ble_cfg_lut -- self-checking bench for ble_cfg_lut (K=4, CFG_W=18).
// Two instances are chained (dut_a.cfg_dout -> dut_b.cfg_din, shared cfg_en);
// single-instance scenarios look at dut_a only. Stimulus pushes expected
// values into a queue; a monitor process samples the DUTs and compares.
module tb_ble_cfg_lut;

  localparam int K     = 4;
  localparam int CFG_W = 18;

  typedef enum int {
    S_OUT_A, S_DONE_A, S_DOUT_A, S_CNT_A, S_SR_A,
    S_OUT_B, S_DONE_B, S_DOUT_B, S_SR_B
  } sig_e;

  typedef struct {
    string       name;
    sig_e        sig;
    logic [31:0] exp;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_en;
  logic         cfg_din;
  logic         a_dout, b_dout;
  logic         a_done, b_done;
  logic [K-1:0] lut_in;
  logic         ce;
  logic         a_out, b_out;

  exp_t exp_q[$];
  int   passes = 0;
  int   total  = 0;

  // Configuration words {FF_INIT, FF_EN, truth table}
  localparam logic [17:0] CFG_AND4  = {1'b0, 1'b0, 16'h8000};
  localparam logic [17:0] CFG_OR4   = {1'b0, 1'b0, 16'hFFFE};
  localparam logic [17:0] CFG_XOR_C = {1'b0, 1'b0, 16'h6996};
  localparam logic [17:0] CFG_XOR_R = {1'b1, 1'b1, 16'h6996};

  always #5 clk = ~clk;

  ble_cfg_lut #(.K(K)) dut_a (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_din(cfg_din),
    .cfg_dout(a_dout), .cfg_done(a_done), .lut_in(lut_in), .ce(ce),
    .ble_out(a_out)
  );

  ble_cfg_lut #(.K(K)) dut_b (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_din(a_dout),
    .cfg_dout(b_dout), .cfg_done(b_done), .lut_in(lut_in), .ce(ce),
    .ble_out(b_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] sample(input sig_e s);
    case (s)
      S_OUT_A:  return 32'(a_out);
      S_DONE_A: return 32'(a_done);
      S_DOUT_A: return 32'(a_dout);
      S_CNT_A:  return 32'(dut_a.cfg_cnt_q);
      S_SR_A:   return 32'(dut_a.cfg_sr_q);
      S_OUT_B:  return 32'(b_out);
      S_DONE_B: return 32'(b_done);
      S_DOUT_B: return 32'(b_dout);
      S_SR_B:   return 32'(dut_b.cfg_sr_q);
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: samples one time unit after expectations appear, with no clock
  // edge in between (stimulus acts just after a falling edge).
  initial begin
    exp_t e;
    forever begin
      wait (exp_q.size() != 0);
      #1;
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check(e.name, sample(e.sig), e.exp);
      end
    end
  end

  task automatic expect_v(input string name, input sig_e s, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.sig  = s;
    e.exp  = v;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for the monitor to consume every queued expectation.
  task automatic drain();
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) #1;
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL monitor_drain: %0d expectations left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Shift bits v[lo] .. v[hi-1], LSB first, one per rising edge. Leaves
  // cfg_en high; call end_cfg() to drop it.
  task automatic shift_bits(input logic [35:0] v, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      cfg_en  = 1'b1;
      cfg_din = v[i];
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic end_cfg();
    cfg_en  = 1'b0;
    cfg_din = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    cfg_en  = 1'b0;
    cfg_din = 1'b0;
    lut_in  = '0;
    ce      = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    expect_v("rst_out", S_OUT_A, 0);
    expect_v("rst_done", S_DONE_A, 0);
    expect_v("rst_dout", S_DOUT_A, 0);
    expect_v("rst_cnt", S_CNT_A, 0);
    drain();
    rst_n = 1'b1;
    idle(1);

    // AND4, combinational
    shift_bits({18'd0, CFG_AND4}, 0, 18);
    end_cfg();
    lut_in = 4'hF;
    expect_v("and4_done", S_DONE_A, 1);
    expect_v("and4_F", S_OUT_A, 1);
    drain();
    lut_in = 4'hE;   // no clock edge between these two comparisons
    expect_v("and4_E", S_OUT_A, 0);
    drain();
    lut_in = 4'h7;
    expect_v("and4_7", S_OUT_A, 0);
    drain();

    // Reconfiguration AND4 -> OR4
    idle(1);
    lut_in = 4'hF;
    expect_v("recfg_pre_out", S_OUT_A, 1);
    drain();
    cfg_en  = 1'b1;
    cfg_din = CFG_OR4[0];
    expect_v("recfg_gate_out", S_OUT_A, 0);
    expect_v("recfg_done_before_edge", S_DONE_A, 1);
    drain();
    @(posedge clk);
    @(negedge clk);
    expect_v("recfg_done_after_edge", S_DONE_A, 0);
    expect_v("recfg_cnt_restart", S_CNT_A, 1);
    drain();
    shift_bits({18'd0, CFG_OR4}, 1, 18);
    end_cfg();
    lut_in = 4'h1;
    expect_v("or4_done", S_DONE_A, 1);
    expect_v("or4_1", S_OUT_A, 1);
    drain();
    lut_in = 4'h0;
    expect_v("or4_0", S_OUT_A, 0);
    drain();

    // Registered XOR, FF_EN=1, FF_INIT=1
    idle(1);
    shift_bits({18'd0, CFG_XOR_R}, 0, 18);
    end_cfg();
    lut_in = 4'b0011;
    expect_v("xor_init", S_OUT_A, 1);
    drain();
    ce = 1'b1;
    @(posedge clk);
    @(negedge clk);
    expect_v("xor_ce_0011", S_OUT_A, 0);
    drain();
    ce     = 1'b0;
    lut_in = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    expect_v("xor_hold", S_OUT_A, 0);
    drain();
    ce = 1'b1;
    @(posedge clk);
    @(negedge clk);
    expect_v("xor_ce_0001", S_OUT_A, 1);
    drain();
    ce = 1'b0;

    // Reset mid-load after 7 shifts (cfg_dout then shows old XOR bit 7 = 1)
    idle(1);
    shift_bits({18'd0, CFG_AND4}, 0, 7);
    expect_v("midload_dout", S_DOUT_A, 1);
    expect_v("midload_out", S_OUT_A, 0);
    expect_v("midload_cnt", S_CNT_A, 7);
    drain();
    rst_n  = 1'b0;
    cfg_en = 1'b0;
    expect_v("rst_async_done", S_DONE_A, 0);
    expect_v("rst_async_out", S_OUT_A, 0);
    expect_v("rst_async_dout", S_DOUT_A, 0);
    drain();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    shift_bits({18'd0, CFG_AND4}, 0, 18);
    end_cfg();
    lut_in = 4'hF;
    expect_v("reload_F", S_OUT_A, 1);
    drain();
    lut_in = 4'hB;
    expect_v("reload_B", S_OUT_A, 0);
    drain();

    // Daisy chain: downstream (OR4) config first, then upstream (AND4)
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    idle(1);
    shift_bits({CFG_AND4, CFG_OR4}, 0, 36);
    end_cfg();
    lut_in = 4'h1;
    expect_v("chain_a_done", S_DONE_A, 1);
    expect_v("chain_b_done", S_DONE_B, 1);
    expect_v("chain_a_1", S_OUT_A, 0);
    expect_v("chain_b_1", S_OUT_B, 1);
    expect_v("chain_b_dout", S_DOUT_B, 0);
    drain();
    lut_in = 4'hF;
    expect_v("chain_a_F", S_OUT_A, 1);
    expect_v("chain_b_F", S_OUT_B, 1);
    drain();
    // 18-bit-only shift: the upstream's previous bits move downstream
    idle(1);
    shift_bits({18'd0, CFG_XOR_C}, 0, 18);
    end_cfg();
    lut_in = 4'h1;
    expect_v("chain18_b_sr", S_SR_B, 32'(CFG_AND4));
    expect_v("chain18_a_sr", S_SR_A, 32'(CFG_XOR_C));
    expect_v("chain18_a_1", S_OUT_A, 1);
    expect_v("chain18_b_1", S_OUT_B, 0);
    drain();

    // Over-shift: 20 bits, only the last 18 retained
    idle(1);
    shift_bits({16'd0, 20'hA5C3E}, 0, 20);
    end_cfg();
    expect_v("over_cnt", S_CNT_A, 18);
    expect_v("over_done", S_DONE_A, 1);
    expect_v("over_sr", S_SR_A, 32'h2970F);
    expect_v("over_dout", S_DOUT_A, 1);
    drain();

    idle(1);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
